// File: rtl/id_stage_pkg.sv
// id_stage_pkg: opcode/funct constants, ALU encodings and the main control decoder.
package id_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [31:0] NOP = 32'h0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        logic    branch;
        logic    jump;
        alu_op_t alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] inst);
        ctrl_t c;
        c = '0;
        case (inst[31:26])
            OP_RTYPE: begin
                c.reg_write = inst[5:0] inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
                c.reg_dst   = c.reg_write;
                c.alu_op    = inst[5:0] == FN_SUB ? ALU_SUB :
                              inst[5:0] == FN_AND ? ALU_AND :
                              inst[5:0] == FN_OR  ? ALU_OR  :
                              inst[5:0] == FN_SLT ? ALU_SLT : ALU_ADD;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.mem_read   = 1'b1;
                c.alu_src    = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            OP_BEQ: begin
                c.branch = 1'b1;
                c.alu_op = ALU_SUB;
            end
            OP_J: c.jump = 1'b1;
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_32x32.sv
// regfile_32x32: two combinational read ports with write-through bypass, r0 hardwired to zero.
module regfile_32x32
    import id_stage_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs[ra1];
    assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID latch, control decode, register read, load-use stall and the ID/EX register.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] IF_Inst,
    input  logic [DW-1:0] IF_PC4,
    input  logic          Flush,
    input  logic          EX_MemRead,
    input  logic [4:0]    EX_Rt,
    input  logic          WB_RegWrite,
    input  logic [4:0]    WB_Rd,
    input  logic [DW-1:0] WB_Data,
    output logic          Stall,
    output logic          ID_RegWrite,
    output logic          ID_MemtoReg,
    output logic          ID_MemRead,
    output logic          ID_MemWrite,
    output logic          ID_ALUSrc,
    output logic          ID_RegDst,
    output logic          ID_Branch,
    output logic          ID_Jump,
    output logic [2:0]    ID_ALUOp,
    output logic [DW-1:0] ID_RD1,
    output logic [DW-1:0] ID_RD2,
    output logic [DW-1:0] ID_Imm,
    output logic [4:0]    ID_Rs,
    output logic [4:0]    ID_Rt,
    output logic [4:0]    ID_Rd,
    output logic [DW-1:0] ID_PC4,
    output logic [DW-1:0] ID_JAddr
);

    logic [DW-1:0] if_inst, if_pc4, rd1, rd2;
    logic [5:0]    op;
    logic [4:0]    rs, rt, rd;
    logic          reads_rs, reads_rt;
    ctrl_t         dec, ctrl_q;

    assign op  = if_inst[31:26];
    assign rs  = if_inst[25:21];
    assign rt  = if_inst[20:16];
    assign rd  = if_inst[15:11];
    assign dec = decode(if_inst);

    // rt is only a source for R-type, sw and beq; for lw/addi it is the destination
    assign reads_rs = op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
    assign reads_rt = op inside {OP_RTYPE, OP_SW, OP_BEQ};
    assign Stall    = !Rst && EX_MemRead && EX_Rt != '0 &&
                      ((reads_rs && EX_Rt == rs) || (reads_rt && EX_Rt == rt));

    regfile_32x32 #(.DW(DW), .NREG(NREG)) u_rf (
        .clk (Clk),
        .rst (Rst),
        .ra1 (rs),
        .ra2 (rt),
        .rd1 (rd1),
        .rd2 (rd2),
        .we  (WB_RegWrite),
        .wa  (WB_Rd),
        .wd  (WB_Data)
    );

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            if_inst <= NOP;
            if_pc4  <= '0;
        end else if (!Stall) begin
            if_inst <= IF_Inst;
            if_pc4  <= IF_PC4;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ctrl_q   <= '0;
            ID_RD1   <= '0;
            ID_RD2   <= '0;
            ID_Imm   <= '0;
            ID_Rs    <= '0;
            ID_Rt    <= '0;
            ID_Rd    <= '0;
            ID_PC4   <= '0;
            ID_JAddr <= '0;
        end else begin
            ctrl_q   <= (Stall || Flush) ? '0 : dec;
            ID_RD1   <= rd1;
            ID_RD2   <= rd2;
            ID_Imm   <= {{(DW-16){if_inst[15]}}, if_inst[15:0]};
            ID_Rs    <= rs;
            ID_Rt    <= rt;
            ID_Rd    <= rd;
            ID_PC4   <= if_pc4;
            ID_JAddr <= {if_pc4[31:28], if_inst[25:0], 2'b00};
        end
    end

    assign {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
            ID_ALUSrc, ID_RegDst, ID_Branch, ID_Jump, ID_ALUOp} = ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized and directed stimulus against a behavioural model of the decode stage.
module tb_id_stage;

    logic        Clk = 1'b0;
    logic        Rst, Flush, EX_MemRead, WB_RegWrite;
    logic [31:0] IF_Inst, IF_PC4, WB_Data;
    logic [4:0]  EX_Rt, WB_Rd;
    logic        Stall, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite;
    logic        ID_ALUSrc, ID_RegDst, ID_Branch, ID_Jump;
    logic [2:0]  ID_ALUOp;
    logic [31:0] ID_RD1, ID_RD2, ID_Imm, ID_PC4, ID_JAddr;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rd;

    id_stage dut (
        .Clk(Clk), .Rst(Rst), .IF_Inst(IF_Inst), .IF_PC4(IF_PC4), .Flush(Flush),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .WB_RegWrite(WB_RegWrite),
        .WB_Rd(WB_Rd), .WB_Data(WB_Data), .Stall(Stall),
        .ID_RegWrite(ID_RegWrite), .ID_MemtoReg(ID_MemtoReg), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst),
        .ID_Branch(ID_Branch), .ID_Jump(ID_Jump), .ID_ALUOp(ID_ALUOp),
        .ID_RD1(ID_RD1), .ID_RD2(ID_RD2), .ID_Imm(ID_Imm), .ID_Rs(ID_Rs),
        .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_PC4(ID_PC4), .ID_JAddr(ID_JAddr)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0;
    bit chk_en = 0;

    // model state: architectural registers, IF/ID contents, expected ID/EX outputs
    logic [31:0] m_regs [32];
    logic [31:0] m_inst, m_pc4;
    bit          m_pc4_ok;
    bit          exp_stall;
    logic [10:0] exp_ctrl, pend_ctrl;
    logic [31:0] exp_rd1, exp_rd2, exp_imm, exp_pc4, exp_ja;
    logic [31:0] pend_rd1, pend_rd2, pend_imm, pend_pc4, pend_ja;
    logic [4:0]  exp_rs, exp_rt, exp_rd, pend_rs, pend_rt, pend_rd;
    bit          exp_pc4_ok, pend_pc4_ok;
    logic [31:0] pc = 32'h0040_0000;

    wire [10:0] dut_ctrl = {ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
                            ID_ALUSrc, ID_RegDst, ID_Branch, ID_Jump, ID_ALUOp};

    task automatic cmp(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // bit order: RegWrite MemtoReg MemRead MemWrite ALUSrc RegDst Branch Jump ALUOp[2:0]
    function automatic logic [10:0] ref_ctrl(input logic [31:0] i);
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h20: return 11'b10000100_000;
                6'h22: return 11'b10000100_001;
                6'h24: return 11'b10000100_010;
                6'h25: return 11'b10000100_011;
                6'h2A: return 11'b10000100_100;
                default: return 11'b0;
            endcase
        end
        case (i[31:26])
            6'h23: return 11'b11101000_000;
            6'h2B: return 11'b00011000_000;
            6'h04: return 11'b00000010_001;
            6'h02: return 11'b00000001_000;
            6'h08: return 11'b10001000_000;
            default: return 11'b0;
        endcase
    endfunction

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (WB_RegWrite && WB_Rd == a) return WB_Data;
        return m_regs[a];
    endfunction

    task automatic eval();
        logic [5:0] op;
        logic [4:0] rs, rt;
        bit src_rs, src_rt;
        op = m_inst[31:26];
        rs = m_inst[25:21];
        rt = m_inst[20:16];
        src_rs = op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08;
        src_rt = op == 6'h00 || op == 6'h2B || op == 6'h04;
        exp_stall = !Rst && EX_MemRead && EX_Rt != 0 &&
                    ((src_rs && EX_Rt == rs) || (src_rt && EX_Rt == rt));
        pend_ctrl   = (Rst || exp_stall || Flush) ? 11'b0 : ref_ctrl(m_inst);
        pend_rd1    = Rst ? 32'h0 : rf_read(rs);
        pend_rd2    = Rst ? 32'h0 : rf_read(rt);
        pend_imm    = Rst ? 32'h0 : {{16{m_inst[15]}}, m_inst[15:0]};
        pend_rs     = Rst ? 5'h0 : rs;
        pend_rt     = Rst ? 5'h0 : rt;
        pend_rd     = Rst ? 5'h0 : m_inst[15:11];
        pend_pc4    = Rst ? 32'h0 : m_pc4;
        pend_ja     = Rst ? 32'h0 : {m_pc4[31:28], m_inst[25:0], 2'b00};
        pend_pc4_ok = Rst || m_pc4_ok;
    endtask

    task automatic commit();
        exp_ctrl = pend_ctrl; exp_rd1 = pend_rd1; exp_rd2 = pend_rd2; exp_imm = pend_imm;
        exp_rs = pend_rs; exp_rt = pend_rt; exp_rd = pend_rd;
        exp_pc4 = pend_pc4; exp_ja = pend_ja; exp_pc4_ok = pend_pc4_ok;
        if (Rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_inst = 32'h0; m_pc4 = 32'h0; m_pc4_ok = 1;
        end else begin
            if (WB_RegWrite && WB_Rd != 0) m_regs[WB_Rd] = WB_Data;
            if (Flush) begin
                m_inst = 32'h0; m_pc4_ok = 0;
            end else if (!exp_stall) begin
                m_inst = IF_Inst; m_pc4 = IF_PC4; m_pc4_ok = 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [31:0] inst, input logic fl,
                        input logic emr, input logic [4:0] ert,
                        input logic wwe, input logic [4:0] wrd, input logic [31:0] wd);
        @(posedge Clk);
        commit();
        chk_en = 1;
        #2;
        pc = pc + 4;
        Rst = rst; IF_Inst = inst; IF_PC4 = pc; Flush = fl;
        EX_MemRead = emr; EX_Rt = ert; WB_RegWrite = wwe; WB_Rd = wrd; WB_Data = wd;
        eval();
        #1;
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp("stall", {31'b0, Stall}, {31'b0, exp_stall});
            cmp("ctrl", {21'b0, dut_ctrl}, {21'b0, exp_ctrl});
            cmp("rd1", ID_RD1, exp_rd1);
            cmp("rd2", ID_RD2, exp_rd2);
            cmp("imm", ID_Imm, exp_imm);
            cmp("rs", {27'b0, ID_Rs}, {27'b0, exp_rs});
            cmp("rt", {27'b0, ID_Rt}, {27'b0, exp_rt});
            cmp("rd", {27'b0, ID_Rd}, {27'b0, exp_rd});
            if (exp_pc4_ok) begin
                cmp("pc4", ID_PC4, exp_pc4);
                cmp("jaddr", ID_JAddr, exp_ja);
            end
        end
    end

    function automatic logic [4:0] rr();
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [5];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        case ($urandom_range(0, 7))
            0: return {6'h00, rr(), rr(), rr(), 5'h0, fns[$urandom_range(0, 4)]};
            1: return {6'h00, rr(), rr(), rr(), 5'h0, 6'($urandom)};
            2: return {6'h23, rr(), rr(), 16'($urandom)};
            3: return {6'h2B, rr(), rr(), 16'($urandom)};
            4: return {6'h04, rr(), rr(), 16'($urandom)};
            5: return {6'h02, 26'($urandom)};
            6: return {6'h08, rr(), rr(), 16'($urandom)};
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        Rst = 1; IF_Inst = 0; IF_PC4 = 0; Flush = 0; EX_MemRead = 0; EX_Rt = 0;
        WB_RegWrite = 0; WB_Rd = 0; WB_Data = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_inst = 0; m_pc4 = 0; m_pc4_ok = 0;
        eval();
        step(1, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        step(1, 32'h0, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        idle();
        cmp("lit_reset_ctrl", {21'b0, dut_ctrl}, 32'h0);
        cmp("lit_reset_rd1", ID_RD1, 32'h0);
        // add r3,r5,r0 after writing r5
        step(0, 32'h0, 0, 0, 5'd0, 1, 5'd5, 32'h1234);
        step(0, 32'h00A01820, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        idle(); idle();
        cmp("lit_add_rd1", ID_RD1, 32'h1234);
        cmp("lit_add_ctrl", {21'b0, dut_ctrl}, {21'b0, 11'b10000100_000});
        cmp("lit_add_rd", {27'b0, ID_Rd}, 32'd3);
        // sw r7,4(r0) with same-cycle write of r7
        step(0, 32'hAC070004, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        step(0, 32'h0, 0, 0, 5'd0, 1, 5'd7, 32'hDEAD);
        idle();
        cmp("lit_sw_rd2", ID_RD2, 32'hDEAD);
        cmp("lit_sw_memwrite", {31'b0, ID_MemWrite}, 32'd1);
        cmp("lit_sw_imm", ID_Imm, 32'd4);
        // load-use on add r9,r8,r0
        step(0, 32'h01004820, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        step(0, 32'h0, 0, 1, 5'd8, 0, 5'd0, 32'h0);
        cmp("lit_lu_stall", {31'b0, Stall}, 32'd1);
        idle();
        cmp("lit_lu_stall_off", {31'b0, Stall}, 32'd0);
        cmp("lit_lu_bubble", {21'b0, dut_ctrl}, 32'h0);
        idle();
        cmp("lit_lu_regwrite", {31'b0, ID_RegWrite}, 32'd1);
        cmp("lit_lu_rd", {27'b0, ID_Rd}, 32'd9);
        // addi r8,r0,1: rt is a destination, no stall
        step(0, 32'h20080001, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        step(0, 32'h0, 0, 1, 5'd8, 0, 5'd0, 32'h0);
        cmp("lit_addi_nostall", {31'b0, Stall}, 32'd0);
        idle();
        cmp("lit_addi_ctrl", {21'b0, dut_ctrl}, {21'b0, 11'b10001000_000});
        // flush while the hazard is active
        step(0, 32'h01004820, 0, 0, 5'd0, 0, 5'd0, 32'h0);
        step(0, 32'h0, 1, 1, 5'd8, 0, 5'd0, 32'h0);
        cmp("lit_fl_stall", {31'b0, Stall}, 32'd1);
        idle();
        cmp("lit_fl_stall_off", {31'b0, Stall}, 32'd0);
        cmp("lit_fl_ctrl0", {21'b0, dut_ctrl}, 32'h0);
        idle();
        cmp("lit_fl_ctrl1", {21'b0, dut_ctrl}, 32'h0);
        // r0 write discarded, beq r0,r0,-1
        step(0, 32'h1000FFFF, 0, 0, 5'd0, 1, 5'd0, 32'hFFFF);
        idle(); idle();
        cmp("lit_beq_rd1", ID_RD1, 32'h0);
        cmp("lit_beq_rd2", ID_RD2, 32'h0);
        cmp("lit_beq_ctrl", {21'b0, dut_ctrl}, {21'b0, 11'b00000010_001});
        cmp("lit_beq_imm", ID_Imm, 32'hFFFFFFFF);
        for (int n = 0; n < 3000; n++) begin
            logic emr;
            emr = exp_stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            step($urandom_range(0, 199) == 0, rand_inst(), $urandom_range(0, 9) == 0,
                 emr, rr(), 1'($urandom), rr(), $urandom);
        end
        @(posedge Clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the pipelined MIPS-subset CPU, directly downstream of instruction fetch.
- Captures the fetched instruction and PC+4 in an IF/ID latch, decodes the main control signals, and reads the 32x32 register file, which has a write-back port.
- Detects load-use hazards, stalling fetch and inserting a bubble.
- Presents all results to execute through a registered ID/EX boundary.

Parameters:
- DW, 32, datapath and instruction width.
- NREG, 32, register count; r0 reads as zero.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- IF_Inst  in  32  fetched instruction.
- IF_PC4  in  32  PC+4 of the fetched instruction.
- Flush  in  1  taken branch/jump resolved downstream; squash the IF/ID contents.
- EX_MemRead  in  1  the instruction now in EX is lw.
- EX_Rt  in  5  destination of that lw.
- WB_RegWrite  in  1  write-back enable.
- WB_Rd  in  5  write-back register.
- WB_Data  in  32  write-back data.
- Stall  out  1  combinational; holds the PC and the IF/ID latch.
- ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst, ID_Branch, ID_Jump  out  1 each  registered controls.
- ID_ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- ID_RD1, ID_RD2  out  32  registered operands.
- ID_Imm  out  32  sign-extended Inst[15:0].
- ID_Rs, ID_Rt, ID_Rd  out  5  register fields.
- ID_PC4  out  32  PC+4.
- ID_JAddr  out  32  {PC4[31:28], Inst[25:0], 2'b00}.

Behaviour:
- Rst (synchronous): IF/ID latch, all ID_* outputs and all 32 registers clear to 0. Stall is 0 during reset.
- IF/ID latch priority, highest first:
  - Rst: clear.
  - Flush: load instruction 0 (NOP). Flush wins over Stall.
  - Stall: hold.
  - Otherwise: load IF_Inst and IF_PC4.
- Decode by opcode Inst[31:26]:
  - 000000 R-type, funct 100000 add / 100010 sub / 100100 and / 100101 or / 101010 slt: RegWrite, RegDst.
  - 100011 lw: RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp add.
  - 101011 sw: MemWrite, ALUSrc, ALUOp add.
  - 000100 beq: Branch, ALUOp sub.
  - 000010 j: Jump.
  - 001000 addi: RegWrite, ALUSrc, ALUOp add.
  - Any other opcode or funct, and the all-zero NOP: all controls 0 (bubble).
- Register file:
  - Written on the rising Clk edge when WB_RegWrite=1 and WB_Rd!=0; writes to r0 are discarded.
  - Reads are combinational on Rs and Rt.
  - Same-cycle write to a register being read returns WB_Data (write-through bypass).
- Load-use hazard: Stall=1 when EX_MemRead=1, EX_Rt!=0, and one of:
  - EX_Rt equals Rs, for any instruction that reads rs (R-type, lw, sw, beq, addi).
  - EX_Rt equals Rt, for any instruction that reads rt (R-type, sw, beq).
- ID/EX register, one cycle of latency:
  - Stall=1 or Flush=1: all control outputs load 0; data fields are don't-care but load the decoded values.
  - Otherwise: decoded values load.
- Stall is held only while the hazard persists. The next cycle the lw has moved to MEM, so Stall lasts exactly 1 cycle per hazard.
- Flush and Stall in the same cycle: the flush applies and Stall is ignored for the IF/ID latch.
- ID_Imm is sign-extended. Shifting for the branch target is done downstream.

Decomposition:
- Shared package/header holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - funct constants;
  - the ALUOp encodings above;
  - NOP = 32'h0.
- One sub-module: regfile_32x32 (two read ports, one write port, r0 hardwired, bypass, synchronous reset).
- Decode, hazard logic and pipeline registers stay in id_stage.

Test Plan:
- Reset, then write r5=32'h1234 via WB; next present IF_Inst add r3,r5,r0 (32'h00A01820) -> after one cycle ID_RD1=32'h1234, ID_RegWrite=1, ID_RegDst=1, ID_ALUOp=000, ID_Rd=3.
- Same-cycle bypass: WB writes r7=32'hDEAD while decoding sw r7,4(r0) (32'hAC070004) -> ID_RD2=32'hDEAD, ID_MemWrite=1, ID_Imm=4.
- Load-use: EX_MemRead=1, EX_Rt=8 while decoding add r9,r8,r0 -> Stall=1 for exactly 1 cycle, ID_* controls 0 that cycle, same instruction decoded next cycle with Stall=0.
- No false stall: EX_MemRead=1, EX_Rt=8 while decoding addi r8,r0,1 (rt is a destination) -> Stall=0.
- Flush during Stall: Flush=1 with the hazard active -> IF/ID holds NOP, next-cycle ID controls all 0, Stall=0.
- Writes to r0 ignored, and immediate sign-extension: WB r0=32'hFFFF then beq r0,r0,-1 (32'h1000FFFF) -> ID_RD1=ID_RD2=0, ID_Branch=1, ID_Imm=32'hFFFFFFFF, ID_ALUOp=001.
